shift_add_multiplier: RTL and testbench

SHIFT_ADD_MULTIPLIER -- requirements
Module: shift_add_multiplier

---
 rtl/shift_add_multiplier_pkg.sv | 13 +
 rtl/carrySelectAdder32bit.sv | 31 +++
 rtl/shift_add_multiplier.sv | 105 ++++++++++
 tb/tb_shift_add_multiplier.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/shift_add_multiplier_pkg.sv
// Shared types and constants for the shift-and-add multiplier.
package shift_add_multiplier_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int ADDER_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage : shift_add_multiplier_pkg

// File: rtl/carrySelectAdder32bit.sv
// 32-bit carry-select adder: 4-bit blocks precompute both carry-in cases,
// and the incoming block carry selects between them.
module carrySelectAdder32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        cin_i,
  output logic [31:0] sum_o,
  output logic        cout_o
);

  logic       blk_carry;
  logic [4:0] res_c0;
  logic [4:0] res_c1;

  // NOTE: every variable written here gets a value before any conditional
  //       use, so no latch can be inferred.
  always_comb begin
    blk_carry = cin_i;
    sum_o     = '0;
    res_c0    = '0;
    res_c1    = '0;
    for (int g = 0; g < 8; g++) begin
      res_c0 = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]};
      res_c1 = {1'b0, a_i[4*g +: 4]} + {1'b0, b_i[4*g +: 4]} + 5'd1;
      sum_o[4*g +: 4] = blk_carry ? res_c1[3:0] : res_c0[3:0];
      blk_carry       = blk_carry ? res_c1[4]   : res_c0[4];
    end
    cout_o = blk_carry;
  end

endmodule : carrySelectAdder32bit

// File: rtl/shift_add_multiplier.sv
// Sequential unsigned multiplier: one add-and-shift step per cycle,
// WIDTH cycles per product. WIDTH must not exceed the 32-bit adder.
module shift_add_multiplier
  import shift_add_multiplier_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CW-1:0]        count_q, count_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [WIDTH-1:0]       add_sum;
  logic                   add_carry;
  logic [ADDER_WIDTH-1:0] adder_a, adder_b, adder_sum;
  logic                   adder_cout;

  // Only add the multiplicand when the current multiplier LSB is set.
  if (WIDTH == ADDER_WIDTH) begin : g_full
    assign adder_a   = acc_q[2*WIDTH-1:WIDTH];
    assign adder_b   = acc_q[0] ? mcand_q : '0;
    assign add_sum   = adder_sum;
    assign add_carry = adder_cout;
  end else begin : g_narrow
    assign adder_a   = {{(ADDER_WIDTH-WIDTH){1'b0}}, acc_q[2*WIDTH-1:WIDTH]};
    assign adder_b   = {{(ADDER_WIDTH-WIDTH){1'b0}}, (acc_q[0] ? mcand_q : '0)};
    assign add_sum   = adder_sum[WIDTH-1:0];
    assign add_carry = adder_sum[WIDTH];
  end

  carrySelectAdder32bit u_adder (
    .a_i    (adder_a),
    .b_i    (adder_b),
    .cin_i  (1'b0),
    .sum_o  (adder_sum),
    .cout_o (adder_cout)
  );

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    product_d = product_q;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          mcand_d = a;
          acc_d   = {{WIDTH{1'b0}}, b};
          count_d = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Carry-out lands in the top bit as the accumulator shifts right.
        acc_d   = {add_carry, add_sum, acc_q[WIDTH-1:1]};
        count_d = count_q + 1'b1;
        if (count_q == LAST) begin
          state_d   = DONE;
          product_d = acc_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  //       register samples its pre-edge inputs regardless of block order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      mcand_q   <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule : shift_add_multiplier

// File: tb/tb_shift_add_multiplier.sv
// Directed self-checking bench for shift_add_multiplier at WIDTH=32.
module tb_shift_add_multiplier;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic        busy, done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  shift_add_multiplier #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  always #5 clk = ~clk;

  // Called at a negedge; returns at the negedge where done is seen (or on timeout).
  task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b,
                        input int inject_at, input bit toggle,
                        input logic [63:0] hold_val,
                        output logic [63:0] prod, output int busy_cycles,
                        output bit got_done, output bit hold_ok);
    start = 1'b1; a = op_a; b = op_b;
    @(negedge clk);
    start = 1'b0;
    busy_cycles = 0; got_done = 1'b0; hold_ok = 1'b1; prod = 'x;
    for (int i = 0; i < 100; i++) begin
      if (done) begin
        got_done = 1'b1;
        prod = product;
        break;
      end
      if (busy) busy_cycles++;
      if (product !== hold_val) hold_ok = 1'b0;
      start = 1'b0;
      if (busy_cycles == inject_at) begin
        start = 1'b1; a = 32'd7; b = 32'd7;
      end
      if (toggle) begin
        a = $urandom; b = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL reset_product got %h want 0", product); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_zero;
    logic [63:0] p; int bc; bit gd, hk;
    run_op(32'd0, 32'd0, -1, 1'b0, 64'd0, p, bc, gd, hk);
    checks++; if (!gd) begin errors++; $display("FAIL zero_done got timeout want done"); end
    checks++; if (bc != 32) begin errors++; $display("FAIL zero_busy_cycles got %0d want 32", bc); end
    checks++; if (p !== 64'd0) begin errors++; $display("FAIL zero_product got %h want 0", p); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL zero_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] p; int bc; bit gd, hk;
    logic [63:0] exp_p [3] = '{64'd34, 64'd192, 64'd192};
    logic [31:0] va    [3] = '{32'd2, 32'd8, 32'd4};
    logic [31:0] vb    [3] = '{32'd17, 32'd24, 32'd48};
    logic [63:0] prev = 64'd0;
    for (int k = 0; k < 3; k++) begin
      run_op(va[k], vb[k], -1, 1'b0, prev, p, bc, gd, hk);
      checks++; if (p !== exp_p[k]) begin errors++; $display("FAIL b2b_product_%0d got %0d want %0d", k, p, exp_p[k]); end
      checks++; if (bc != 32) begin errors++; $display("FAIL b2b_busy_cycles_%0d got %0d want 32", k, bc); end
      checks++; if (!hk) begin errors++; $display("FAIL b2b_hold_%0d got changed want %0d", k, prev); end
      prev = exp_p[k];
    end
    @(negedge clk);
  endtask

  task automatic test_carry;
    logic [63:0] p; int bc; bit gd, hk;
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, 1'b0, 64'd192, p, bc, gd, hk);
    checks++; if (p !== 64'hFFFF_FFFE_0000_0001) begin
      errors++; $display("FAIL carry_product got %h want fffffffe00000001", p);
    end
    @(negedge clk);
  endtask

  task automatic test_start_ignored;
    logic [63:0] p; int bc; bit gd, hk;
    run_op(32'd3, 32'd5, 10, 1'b0, 64'hFFFF_FFFE_0000_0001, p, bc, gd, hk);
    checks++; if (p !== 64'd15) begin errors++; $display("FAIL ignore_product got %0d want 15", p); end
    checks++; if (bc != 32) begin errors++; $display("FAIL ignore_busy_cycles got %0d want 32", bc); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort;
    logic [63:0] p; int bc; bit gd, hk; bit saw_done;
    start = 1'b1; a = 32'd6; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (12) @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL abort_busy_before got %b want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
    checks++; if (product !== 64'd0) begin errors++; $display("FAIL abort_product got %0d want 0", product); end
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (done) saw_done = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_done) begin errors++; $display("FAIL abort_no_done got pulse want none"); end
    run_op(32'd6, 32'd9, -1, 1'b0, 64'd0, p, bc, gd, hk);
    checks++; if (p !== 64'd54) begin errors++; $display("FAIL abort_rerun_product got %0d want 54", p); end
    @(negedge clk);
  endtask

  task automatic test_toggle;
    logic [63:0] p; int bc; bit gd, hk;
    run_op(32'd1000, 32'd1000, -1, 1'b1, 64'd54, p, bc, gd, hk);
    checks++; if (p !== 64'd1000000) begin errors++; $display("FAIL toggle_product got %0d want 1000000", p); end
    checks++; if (!hk) begin errors++; $display("FAIL toggle_hold got changed want 54"); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_zero();
    test_back_to_back();
    test_carry();
    test_start_ignored();
    test_reset_abort();
    test_toggle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_add_multiplier
